ecc_sed_decoder: RTL and testbench

Receive-side counterpart of the single-error-detect (SED) encoder. Accepts 13-bit codewords `{parity, data[11:0]}` under even parity, checks them, and strips the parity bit. Each data word is forwarded with a per-word error flag through a 2-entry output FIFO with valid/ready backpressure. Keeps a saturating error counter and a sticky error flag for status readout.

---
 rtl/ecc_sed_decoder.sv | 101 ++++++++++
 tb/tb_ecc_sed_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ecc_sed_decoder.sv
// Even-parity single-error-detect decoder: strips the parity bit, flags odd-flip words,
// buffers {err, data} in a 2-entry FIFO and keeps a saturating error count plus sticky flag.
module ecc_sed_decoder #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enc_valid_i,
    output logic              enc_ready_o,
    input  logic [DATA_W:0]   enc_codeword_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [DATA_W-1:0] dec_data_o,
    output logic              dec_err_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic              err_sticky_o,
    input  logic              err_clr_i
);

    localparam int ENTRY_W = DATA_W + 1;

    logic [ENTRY_W-1:0] mem_q [2];
    logic [ENTRY_W-1:0] mem_d [2];
    logic               head_q, head_d;
    logic               tail_q, tail_d;
    logic [1:0]         occ_q, occ_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sticky_q, sticky_d;

    logic push;
    logic pop;
    logic syndrome;

    // Handshake flags come from registered occupancy only, so no input reaches them combinationally.
    assign enc_ready_o = (occ_q != 2'd2);
    assign dec_valid_o = (occ_q != 2'd0);
    assign {dec_err_o, dec_data_o} = mem_q[head_q];
    assign err_cnt_o    = cnt_q;
    assign err_sticky_o = sticky_q;

    assign push     = enc_valid_i & enc_ready_o;
    assign pop      = dec_valid_o & dec_ready_i;
    assign syndrome = ^enc_codeword_i;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        head_d   = head_q;
        tail_d   = tail_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;

        if (push) begin
            mem_d[tail_q] = {syndrome, enc_codeword_i[DATA_W-1:0]};
            tail_d        = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 2'd1;
        end

        // Clear first so an error accepted in the same cycle is counted after it.
        if (err_clr_i) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
        if (push && syndrome) begin
            sticky_d = 1'b1;
            if (cnt_d != {CNT_W{1'b1}}) begin
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            occ_q    <= 2'd0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            head_q   <= head_d;
            tail_q   <= tail_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_ecc_sed_decoder.sv
// Self-checking bench for ecc_sed_decoder: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ecc_sed_decoder;

    localparam int DATA_W = 12;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enc_valid = 1'b0;
    logic              enc_ready;
    logic [DATA_W:0]   enc_codeword = '0;
    logic              dec_valid;
    logic              dec_ready = 1'b0;
    logic [DATA_W-1:0] dec_data;
    logic              dec_err;
    logic [CNT_W-1:0]  err_cnt;
    logic              err_sticky;
    logic              err_clr = 1'b0;

    int nCompared = 0;
    int nFailed   = 0;

    // Reference model: FIFO contents as a queue of {err, data}, plus status.
    logic [DATA_W:0] modelQ [$];
    int              modelCnt = 0;
    bit              modelSticky = 1'b0;

    ecc_sed_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enc_valid_i    (enc_valid),
        .enc_ready_o    (enc_ready),
        .enc_codeword_i (enc_codeword),
        .dec_valid_o    (dec_valid),
        .dec_ready_i    (dec_ready),
        .dec_data_o     (dec_data),
        .dec_err_o      (dec_err),
        .err_cnt_o      (err_cnt),
        .err_sticky_o   (err_sticky),
        .err_clr_i      (err_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update at each active edge, from the occupancy seen before the edge.
    always @(posedge clk) begin
        if (rst_n) begin
            bit accept;
            bit drain;
            bit isErr;
            accept = enc_valid && (modelQ.size() < 2);
            drain  = dec_ready && (modelQ.size() > 0);
            isErr  = ($countones(enc_codeword) % 2) == 1;
            if (drain) void'(modelQ.pop_front());
            if (accept) modelQ.push_back({isErr, enc_codeword[DATA_W-1:0]});
            if (err_clr) begin
                modelCnt    = 0;
                modelSticky = 1'b0;
            end
            if (accept && isErr) begin
                modelSticky = 1'b1;
                if (modelCnt < (1 << CNT_W) - 1) modelCnt++;
            end
        end
    end

    always @(negedge rst_n) begin
        modelQ.delete();
        modelCnt    = 0;
        modelSticky = 1'b0;
    end

    // Single compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        checkOutput("dec_valid", int'(dec_valid), int'(modelQ.size() != 0));
        checkOutput("enc_ready", int'(enc_ready), int'(modelQ.size() != 2));
        checkOutput("err_cnt", int'(err_cnt), modelCnt);
        checkOutput("err_sticky", int'(err_sticky), int'(modelSticky));
        if (modelQ.size() != 0) begin
            checkOutput("dec_data", int'(dec_data), int'(modelQ[0][DATA_W-1:0]));
            checkOutput("dec_err", int'(dec_err), int'(modelQ[0][DATA_W]));
        end
    end

    // Called at a falling edge: drive inputs, then let one active edge pass.
    task automatic applyStimulus(input bit v, input logic [DATA_W:0] cw, input bit r, input bit clr);
        enc_valid    = v;
        enc_codeword = cw;
        dec_ready    = r;
        err_clr      = clr;
        @(negedge clk);
    endtask

    function automatic logic [DATA_W:0] badWord(input logic [DATA_W-1:0] d);
        return {~(^d), d};
    endfunction

    initial begin
        $display("[TB] start");
        #1;
        checkOutput("reset enc_ready", int'(enc_ready), 1);
        checkOutput("reset dec_valid", int'(dec_valid), 0);
        checkOutput("reset dec_data", int'(dec_data), 0);
        checkOutput("reset err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean word: 0xABC has popcount 7, so parity bit 1 gives even parity.
        applyStimulus(1'b1, 13'h1ABC, 1'b1, 1'b0);
        checkOutput("clean valid", int'(dec_valid), 1);
        checkOutput("clean data", int'(dec_data), 'hABC);
        checkOutput("clean err", int'(dec_err), 0);
        checkOutput("clean cnt", int'(err_cnt), 0);

        // Single flips, then a double flip that goes undetected.
        applyStimulus(1'b1, 13'h0ABC, 1'b1, 1'b0);
        checkOutput("flip1 data", int'(dec_data), 'hABC);
        checkOutput("flip1 err", int'(dec_err), 1);
        applyStimulus(1'b1, 13'h1000, 1'b1, 1'b0);
        checkOutput("flip2 data", int'(dec_data), 'h000);
        checkOutput("flip2 err", int'(dec_err), 1);
        checkOutput("flip cnt", int'(err_cnt), 2);
        checkOutput("flip sticky", int'(err_sticky), 1);
        applyStimulus(1'b1, 13'h1ABF, 1'b1, 1'b0);
        checkOutput("double flip data", int'(dec_data), 'hABF);
        checkOutput("double flip err", int'(dec_err), 0);
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0);

        // Backpressure: two absorbed, third held until the first pop.
        applyStimulus(1'b1, 13'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 13'h1001, 1'b0, 1'b0);
        checkOutput("bp full ready", int'(enc_ready), 0);
        applyStimulus(1'b1, 13'h1002, 1'b0, 1'b0);
        checkOutput("bp stall data", int'(dec_data), 'h000);
        applyStimulus(1'b1, 13'h1002, 1'b0, 1'b0);
        checkOutput("bp stall data2", int'(dec_data), 'h000);
        checkOutput("bp stall ready", int'(enc_ready), 0);
        applyStimulus(1'b1, 13'h1002, 1'b1, 1'b0);
        checkOutput("bp pop1 data", int'(dec_data), 'h001);
        checkOutput("bp pop1 ready", int'(enc_ready), 1);
        applyStimulus(1'b1, 13'h1002, 1'b1, 1'b0);
        checkOutput("bp pop2 data", int'(dec_data), 'h002);
        checkOutput("bp pop2 err", int'(dec_err), 0);
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0);
        checkOutput("bp drained", int'(dec_valid), 0);

        // Simultaneous push/pop at one entry keeps order and occupancy.
        applyStimulus(1'b1, 13'h1003, 1'b0, 1'b0);
        applyStimulus(1'b1, 13'h0004, 1'b1, 1'b0);
        checkOutput("pushpop head", int'(dec_data), 'h004);
        checkOutput("pushpop err", int'(dec_err), 1);
        checkOutput("pushpop ready", int'(enc_ready), 1);
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0);
        checkOutput("pushpop single", int'(dec_valid), 0);

        // Randomized traffic, compared continuously against the model.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(bit'($urandom_range(0, 3) != 0), 13'($urandom),
                          bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 40) == 0));
        end
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0);

        // Saturation and clear.
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b1, badWord(12'($urandom)), 1'b1, 1'b0);
        end
        checkOutput("sat cnt", int'(err_cnt), 255);
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b1);
        checkOutput("clr cnt", int'(err_cnt), 0);
        checkOutput("clr sticky", int'(err_sticky), 0);
        applyStimulus(1'b1, 13'h0ABC, 1'b1, 1'b1);
        checkOutput("clr+err cnt", int'(err_cnt), 1);
        checkOutput("clr+err sticky", int'(err_sticky), 1);

        // Async reset with a full FIFO and err_cnt = 5.
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, badWord(12'(i)), 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 13'h1ABC, 1'b0, 1'b0);
        applyStimulus(1'b1, 13'h1ABC, 1'b0, 1'b0);
        checkOutput("pre-reset cnt", int'(err_cnt), 5);
        checkOutput("pre-reset ready", int'(enc_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async dec_valid", int'(dec_valid), 0);
        checkOutput("async err_cnt", int'(err_cnt), 0);
        checkOutput("async sticky", int'(err_sticky), 0);
        checkOutput("async enc_ready", int'(enc_ready), 1);
        enc_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 13'h1ABC, 1'b1, 1'b0);
        checkOutput("post-reset valid", int'(dec_valid), 1);
        checkOutput("post-reset data", int'(dec_data), 'hABC);
        checkOutput("post-reset err", int'(dec_err), 0);
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
